// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0]  PS2_BREAK           = 8'hF0;
  localparam logic [7:0]  PS2_EXT             = 8'hE0;
  localparam int unsigned PS2_FRAME_DATA_BITS = 8;

  // True for the two prefix bytes that modify the next scan code.
  function automatic logic ps2_is_prefix(input logic [7:0] b);
    return (b == PS2_BREAK) || (b == PS2_EXT);
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// 2-FF synchronizer followed by a saturating glitch filter; also
// reports a single-cycle falling edge of the filtered level.
module ps2_sync_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4,
  parameter logic        RESET_VAL  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic       s1, s2;
  logic [3:0] cnt;
  logic       prev;

  // Two-stage synchronizer for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Filtered level flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= RESET_VAL;
      cnt  <= '0;
    end else if (s2 == dout) begin
      cnt <= '0;
    end else if (cnt == 4'(FILTER_LEN - 1)) begin
      dout <= s2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  // Delayed filtered level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= RESET_VAL;
    else        prev <= dout;
  end

  assign fall = prev & ~dout;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, resolves F0/E0
// prefixes and emits one event per key action.
// Optional build macro: PS2_KEYCODE_RX_PARITY_EN enables odd-parity checking.
// The break flag output is named key_release because "release" is a
// reserved word in the language.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_release,
  output logic       extended,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_t  state, state_nx;
  logic        clk_f, fall;
  logic        data_f, data_fall_unused;
  logic [7:0]  shreg;
  logic [3:0]  bitcnt;
  logic [TW-1:0] tcnt;
  logic        timeout;
  logic        break_pend, ext_pend;
  logic        accept, err;
  logic        parity_bad;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN),
    .RESET_VAL  (1'b1)
  ) u_clk_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ps2_clk),
    .dout  (clk_f),
    .fall  (fall)
  );

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN),
    .RESET_VAL  (1'b1)
  ) u_data_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ps2_data),
    .dout  (data_f),
    .fall  (data_fall_unused)
  );

`ifdef PS2_KEYCODE_RX_PARITY_EN
  logic par;

  // Parity bit captured for the odd-parity check at the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         par <= 1'b0;
    else if (state == PARITY && fall)   par <= data_f;
  end

  assign parity_bad = ~(^{par, shreg});
`else
  assign parity_bad = 1'b0;
`endif

  assign timeout = (tcnt == TW'(TIMEOUT_CYCLES));

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic plus byte-accepted / error strobes.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE: begin
        if (fall && !data_f) state_nx = DATA;
      end
      DATA: begin
        if (fall && bitcnt == 4'(PS2_FRAME_DATA_BITS - 1)) state_nx = PARITY;
      end
      PARITY: begin
        if (fall) state_nx = STOP;
      end
      STOP: begin
        if (fall) begin
          state_nx = IDLE;
          if (!data_f || parity_bad) err    = 1'b1;
          else                       accept = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // An edge that arrives together with the timeout still counts.
    if (state != IDLE && !fall && timeout) begin
      state_nx = IDLE;
      err      = 1'b1;
    end
  end

  // Inactivity counter: cleared by every edge, held at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     tcnt <= '0;
    else if (state == IDLE || fall) tcnt <= '0;
    else if (!timeout)              tcnt <= tcnt + TW'(1);
  end

  // Shift register and bit counter, LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (fall) begin
      if (state == IDLE && !data_f) begin
        shreg  <= '0;
        bitcnt <= '0;
      end else if (state == DATA) begin
        shreg  <= {data_f, shreg[7:1]};
        bitcnt <= bitcnt + 4'd1;
      end
    end
  end

  // Prefix resolution and registered event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keycode     <= '0;
      key_release <= 1'b0;
      extended    <= 1'b0;
      key_valid   <= 1'b0;
      frame_err   <= 1'b0;
      break_pend  <= 1'b0;
      ext_pend    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (err) begin
        frame_err  <= 1'b1;
        break_pend <= 1'b0;
        ext_pend   <= 1'b0;
      end else if (accept) begin
        if (shreg == PS2_BREAK) begin
          break_pend <= 1'b1;
        end else if (shreg == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else begin
          key_valid   <= 1'b1;
          keycode     <= shreg;
          key_release <= break_pend;
          extended    <= ext_pend;
          break_pend  <= 1'b0;
          ext_pend    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/ps2_keycode_rx.md
# ps2_keycode_rx

Receives the PS/2 keyboard serial stream (device-driven `ps2_clk`/`ps2_data`), deframes 11-bit frames and resolves the `0xF0` break and `0xE0` extended prefixes. Emits one single-cycle event per key action, carrying the scan code and release/extended flags. It sits directly upstream of the keycode decoder, which consumes `keycode` combinationally. All logic runs in the system clock domain.

## Interface

Parameters:

- `FILTER_LEN`, default 4: consecutive equal synchronized samples required before the filtered `ps2_clk`/`ps2_data` level changes (range 1–15).
- `TIMEOUT_CYCLES`, default 50000: system clocks without a filtered `ps2_clk` falling edge, mid-frame, before the frame is aborted (1 ms at 50 MHz).

Ports:

- `clk` in 1: system clock, single clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `keycode` out 8: last resolved scan code, held until the next event.
- `release` out 1: `keycode` event is a key release (break).
- `extended` out 1: `keycode` event was `0xE0`-prefixed.
- `key_valid` out 1: one-cycle pulse; `keycode`/`release`/`extended` are valid in that cycle.
- `frame_err` out 1: one-cycle pulse on a framing, parity or timeout error.

## Operation

Input conditioning:
- Each pin passes through a 2-FF synchronizer, then a saturating filter of `FILTER_LEN` samples.
- A falling edge is detected on the filtered `ps2_clk`. All bit sampling uses filtered `ps2_data` in the edge-detect cycle.

Frame FSM:
- States: `IDLE`, `DATA`, `PARITY`, `STOP`.
- `IDLE`: on a falling edge, if data = 0 (start bit), clear the shift register and bit count, then go to `DATA`. If data = 1, stay in `IDLE`; no error.
- `DATA`: shift bits in LSB first. After the 8th edge go to `PARITY`.
- `PARITY`: capture the parity bit, go to `STOP`.
- `STOP`: data must be 1, else framing error. On success, hand the byte to the prefix logic and go to `IDLE`.
- Timeout: a counter resets on every falling edge and counts only outside `IDLE`. When it reaches `TIMEOUT_CYCLES`, pulse `frame_err` and go to `IDLE`. In `IDLE` the counter holds at 0.
- Any error clears `break_pend` and `ext_pend` and does not pulse `key_valid`.

Prefix resolution, per accepted byte:
- `0xF0`: set `break_pend`; no event.
- `0xE0`: set `ext_pend`; no event.
- Any other byte: pulse `key_valid`, drive `keycode` = byte, `release` = `break_pend`, `extended` = `ext_pend`, then clear both pending flags.
- `0xE0 0xF0 X` yields one event: `release`=1, `extended`=1.
- Repeated prefixes are idempotent: `F0 F0 X` is the same as `F0 X`.

Reset values:
- `keycode`=0x00, `release`=0, `extended`=0, `key_valid`=0, `frame_err`=0.
- FSM in `IDLE`; filters preset to 1 (idle bus level); pending flags and counters 0.
- Reset mid-frame discards the partial frame. The next start bit after reset release is decoded normally.

## Timing

- Latency: `key_valid` asserts in the cycle after the clock edge at which the stop-bit falling edge is detected. From the pin, that is 2 (sync) + `FILTER_LEN` + 1 cycles after the raw `ps2_clk` fall.
- `frame_err` for stop/parity errors has the same latency. For timeout, it asserts in the cycle after the counter reaches `TIMEOUT_CYCLES`.
- `key_valid` and `frame_err` are never high in the same cycle. Each is high for exactly one cycle.
- `keycode`, `release` and `extended` change only in a `key_valid` cycle. They are registered outputs.
- Minimum PS/2 half-period (≥30 µs) must exceed `FILTER_LEN`+3 system clocks. Integration guarantees this.

## Configuration

`PS2_KEYCODE_RX_PARITY_EN`:
- Defined: the bit captured in `PARITY` must make the 9 bits (data + parity) odd. Otherwise, at `STOP`, the frame is dropped, `frame_err` pulses and the pending flags clear. The stop-bit check still applies.
- Undefined: the parity bit is sampled and ignored. Only start, stop and timeout errors are detected.

## Structure

- `ps2_pkg` holds:
  - the `ps2_state_t` enum (`IDLE`/`DATA`/`PARITY`/`STOP`);
  - `PS2_BREAK` = 8'hF0;
  - `PS2_EXT` = 8'hE0;
  - `PS2_FRAME_DATA_BITS` = 8.
- One sub-module, `ps2_sync_filter`: 2-FF synchronizer plus saturating counter filter, parameterized by `FILTER_LEN` and reset value. It is instantiated twice (clock and data); the clock instance also provides a falling-edge output.

## Test plan

- Frame 0x15 (parity 0, stop 1) → exactly one `key_valid` pulse with `keycode`=0x15, `release`=0, `extended`=0; `frame_err` stays 0.
- Frames F0, 1D → no event after F0; one event with `keycode`=0x1D, `release`=1, `extended`=0.
- Frames E0, F0, 5A → one event with `keycode`=0x5A, `release`=1, `extended`=1. A following frame 0x1C gives `release`=0, `extended`=0.
- Frame 0x1B with the parity bit inverted:
  - with `PS2_KEYCODE_RX_PARITY_EN` defined → `frame_err` pulse, no `key_valid`;
  - with it undefined → `key_valid` with `keycode`=0x1B.
- F0, then start + 4 data bits, then `ps2_clk` held high for `TIMEOUT_CYCLES`+10 → one `frame_err` pulse. A following frame 0x1C gives `release`=0 (pending flag cleared).
- Assert `rst_n`=0 after 6 bits of a frame → all outputs return to reset values. Release reset, send 0x15 → correct event, no error.
